// File: rtl/i2c_pkg.sv
// Shared types for the I2C slave: FSM state encoding and byte geometry.
// Pure declarations; no logic, latency or flow control of its own.
package i2c_pkg;

   localparam int BYTE_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ACK_ADDR,
      RX,
      ACK_RX,
      TX,
      WAIT_ACK
   } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises raw SCL/SDA and emits registered rise/fall/START/STOP pulses, SYNC_STAGES+1 cycles after the pin.
// No backpressure: pulses are single-cycle and must be consumed in the cycle they appear.
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_lvl
);

   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic scl_prev_q, scl_prev_d;
   logic sda_prev_q, sda_prev_d;
   logic scl_rise_q, scl_rise_d;
   logic scl_fall_q, scl_fall_d;
   logic start_q, start_d;
   logic stop_q, stop_d;
   logic scl_s, sda_s;

   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_s      = scl_sync_q[SYNC_STAGES-1];
      sda_s      = sda_sync_q[SYNC_STAGES-1];
      scl_prev_d = scl_s;
      sda_prev_d = sda_s;
      scl_rise_d = scl_s & ~scl_prev_q;
      scl_fall_d = ~scl_s & scl_prev_q;
      // SDA may only be treated as a condition while SCL is steadily high
      start_d    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
      stop_d     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         scl_rise_q <= 1'b0;
         scl_fall_q <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_prev_d;
         sda_prev_q <= sda_prev_d;
         scl_rise_q <= scl_rise_d;
         scl_fall_q <= scl_fall_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
      end
   end

   assign scl_rise  = scl_rise_q;
   assign scl_fall  = scl_fall_q;
   assign start_det = start_q;
   assign stop_det  = stop_q;
   // sda_prev_q is the SDA level aligned with the registered pulses
   assign sda_lvl   = sda_prev_q;

endmodule

// File: rtl/i2c_slave_core.sv
// Byte-level I2C slave: START/STOP, 7-bit address match, write receive, read serve, ACK drive; acts one cycle after each conditioned SCL edge.
// No backpressure or clock stretching: rx_valid/tx_req are one-cycle pulses the application must service on the spot.
module i2c_slave_core
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = 7'h42,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       tx_req,
   input  logic [7:0] tx_data,
   output logic       rw,
   output logic       busy
);

   localparam logic [3:0] CNT_DONE = 4'(BYTE_BITS);

   logic scl_rise, scl_fall, start_det, stop_det, sda_lvl;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       sda_oe_q, sda_oe_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       rw_q, rw_d;
   logic       busy_q, busy_d;
   logic       load_tx;
   logic [7:0] shift_in;
   logic [3:0] cnt_inc;

   i2c_bus_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_bus_sync (
      .clk       (clk),
      .reset     (reset),
      .scl_i     (scl_i),
      .sda_i     (sda_i),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_lvl   (sda_lvl)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      sda_oe_d   = sda_oe_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rw_d       = rw_q;
      busy_d     = busy_q;
      load_tx    = 1'b0;
      tx_req     = 1'b0;
      shift_in   = {shift_q[6:0], sda_lvl};
      cnt_inc    = cnt_q + 4'd1;

      if (stop_det) begin
         state_d  = IDLE;
         cnt_d    = 4'd0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else if (start_det) begin
         state_d  = ADDR;
         cnt_d    = 4'd0;
         shift_d  = 8'd0;
         sda_oe_d = 1'b0;
      end else begin
         case (state_q)
            ADDR: if (scl_rise) begin
               shift_d = shift_in;
               cnt_d   = cnt_inc;
               if (cnt_inc == CNT_DONE) begin
                  rw_d  = sda_lvl;
                  cnt_d = 4'd0;
                  state_d = (shift_in[7:1] == SLAVE_ADDR) ? ACK_ADDR : IDLE;
               end
            end
            // cnt 0: first fall starts the ACK; cnt 1: second fall ends it
            ACK_ADDR: if (scl_fall) begin
               if (cnt_q == 4'd0) begin
                  sda_oe_d = 1'b1;
                  busy_d   = 1'b1;
                  cnt_d    = 4'd1;
               end else if (rw_q) begin
                  load_tx = 1'b1;
               end else begin
                  sda_oe_d = 1'b0;
                  cnt_d    = 4'd0;
                  state_d  = RX;
               end
            end
            RX: if (scl_rise) begin
               shift_d = shift_in;
               cnt_d   = cnt_inc;
               if (cnt_inc == CNT_DONE) begin
                  rx_data_d  = shift_in;
                  rx_valid_d = 1'b1;
                  cnt_d      = 4'd0;
                  state_d    = ACK_RX;
               end
            end
            ACK_RX: if (scl_fall) begin
               if (cnt_q == 4'd0) begin
                  sda_oe_d = 1'b1;
                  cnt_d    = 4'd1;
               end else begin
                  sda_oe_d = 1'b0;
                  cnt_d    = 4'd0;
                  state_d  = RX;
               end
            end
            // cnt counts bits already placed on the bus
            TX: if (scl_fall) begin
               if (cnt_q == CNT_DONE) begin
                  sda_oe_d = 1'b0;
                  cnt_d    = 4'd0;
                  state_d  = WAIT_ACK;
               end else begin
                  shift_d  = {shift_q[6:0], 1'b0};
                  sda_oe_d = ~shift_q[6];
                  cnt_d    = cnt_inc;
               end
            end
            WAIT_ACK: begin
               if (scl_rise) begin
                  if (sda_lvl) begin
                     sda_oe_d = 1'b0;
                     busy_d   = 1'b0;
                     state_d  = IDLE;
                  end else begin
                     cnt_d = 4'd1;
                  end
               end else if (scl_fall && cnt_q == 4'd1) begin
                  load_tx = 1'b1;
               end
            end
            default: ;
         endcase

         if (load_tx) begin
            tx_req   = 1'b1;
            shift_d  = tx_data;
            sda_oe_d = ~tx_data[BYTE_BITS-1];
            cnt_d    = 4'd1;
            state_d  = TX;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         shift_q    <= 8'd0;
         sda_oe_q   <= 1'b0;
         rx_data_q  <= 8'd0;
         rx_valid_q <= 1'b0;
         rw_q       <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         sda_oe_q   <= sda_oe_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rw_q       <= rw_d;
         busy_q     <= busy_d;
      end
   end

   assign sda_oe   = sda_oe_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign rw       = rw_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_core.sv
// Bench for i2c_slave_core: a bit-banged I2C master drives directed and random transactions,
// and every observation is compared against a transaction-level model of what the slave should do.
module tb_i2c_slave_core;
   import i2c_pkg::*;

   localparam int Q = 5;
   localparam logic [6:0] MY_ADDR = 7'h42;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       sda_oe, rx_valid, tx_req, rw, busy;
   logic [7:0] rx_data;
   logic       sda_bus;

   assign sda_bus = sda_m & ~sda_oe;

   i2c_slave_core #(
      .SLAVE_ADDR  (MY_ADDR),
      .SYNC_STAGES (2)
   ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .scl_i    (scl_m),
      .sda_i    (sda_bus),
      .sda_oe   (sda_oe),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_req   (tx_req),
      .tx_data  (tx_data),
      .rw       (rw),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [7:0] rx_got[$];
   int tx_req_cnt  = 0;
   int oe_cnt      = 0;
   int overlap_cnt = 0;

   always @(negedge clk) begin
      if (rx_valid) rx_got.push_back(rx_data);
      if (tx_req) tx_req_cnt++;
      if (sda_oe) oe_cnt++;
      if (rx_valid && tx_req) overlap_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic mbit(input logic b, output logic r);
      sda_m = b;
      tick(Q);
      scl_m = 1'b1;
      tick(Q);
      r = sda_bus;
      tick(Q);
      scl_m = 1'b0;
      tick(Q);
   endtask

   task automatic mstart();
      sda_m = 1'b1;
      tick(Q);
      scl_m = 1'b1;
      tick(Q);
      sda_m = 1'b0;
      tick(Q);
      scl_m = 1'b0;
      tick(Q);
   endtask

   task automatic mstop();
      sda_m = 1'b0;
      tick(Q);
      scl_m = 1'b1;
      tick(Q);
      sda_m = 1'b1;
      tick(2 * Q);
   endtask

   task automatic wbyte(input logic [7:0] d, output logic acked);
      logic r;
      for (int i = 7; i >= 0; i--) mbit(d[i], r);
      mbit(1'b1, r);
      acked = ~r;
   endtask

   task automatic rbyte(input logic mack, input logic [7:0] next_tx, output logic [7:0] d);
      logic r;
      d = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         mbit(1'b1, r);
         d[i] = r;
      end
      tx_data = next_tx;
      mbit(~mack, r);
   endtask

   function automatic logic [7:0] byte_of(input logic [23:0] dat, input int k);
      return dat[23 - 8 * k -: 8];
   endfunction

   // Model: a write is acknowledged only for our address; each acked byte reaches the application once.
   task automatic do_write(input logic [6:0] addr, input int n, input logic [23:0] dat);
      logic a;
      logic exp_ack;
      exp_ack = (addr == MY_ADDR);
      rx_got.delete();
      oe_cnt = 0;
      mstart();
      wbyte({addr, 1'b0}, a);
      chk("wr_addr_ack", 32'(a), 32'(exp_ack));
      chk("wr_busy", 32'(busy), 32'(exp_ack));
      if (exp_ack) chk("wr_rw", 32'(rw), 32'd0);
      for (int k = 0; k < n; k++) begin
         wbyte(byte_of(dat, k), a);
         chk("wr_data_ack", 32'(a), 32'(exp_ack));
      end
      if (!exp_ack) chk("wr_nack_oe_cycles", 32'(oe_cnt), 32'd0);
      mstop();
      chk("wr_busy_after_stop", 32'(busy), 32'd0);
      chk("wr_oe_after_stop", 32'(sda_oe), 32'd0);
      chk("wr_rx_count", 32'(rx_got.size()), exp_ack ? 32'(n) : 32'd0);
      if (exp_ack && rx_got.size() == n)
         for (int k = 0; k < n; k++) chk("wr_rx_data", 32'(rx_got[k]), 32'(byte_of(dat, k)));
   endtask

   // Model: a read serves the application's bytes in order, one tx_req per byte, ending on master NACK.
   task automatic do_read(input logic [6:0] addr, input int n, input logic [23:0] dat);
      logic a;
      logic exp_ack;
      logic [7:0] d;
      int req0;
      exp_ack = (addr == MY_ADDR);
      rx_got.delete();
      req0 = tx_req_cnt;
      tx_data = byte_of(dat, 0);
      mstart();
      wbyte({addr, 1'b1}, a);
      chk("rd_addr_ack", 32'(a), 32'(exp_ack));
      if (exp_ack) begin
         chk("rd_rw", 32'(rw), 32'd1);
         chk("rd_busy", 32'(busy), 32'd1);
         for (int k = 0; k < n; k++) begin
            rbyte(k != n - 1, (k + 1 < n) ? byte_of(dat, k + 1) : 8'h00, d);
            chk("rd_data", 32'(d), 32'(byte_of(dat, k)));
         end
         chk("rd_oe_after_nack", 32'(sda_oe), 32'd0);
         chk("rd_busy_after_nack", 32'(busy), 32'd0);
         chk("rd_idle_after_nack", 32'(u_dut.state_q), 32'(IDLE));
      end
      chk("rd_tx_req_count", 32'(tx_req_cnt - req0), exp_ack ? 32'(n) : 32'd0);
      mstop();
      chk("rd_no_rx", 32'(rx_got.size()), 32'd0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic a, r;
      logic [7:0] d;
      int req0;

      tick(4);
      chk("rst_sda_oe", 32'(sda_oe), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      tick(4);
      chk("rst_rx_data", 32'(rx_data), 32'd0);
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_tx_req", 32'(tx_req), 32'd0);
      chk("rst_rw", 32'(rw), 32'd0);

      do_write(7'h42, 2, 24'hA53C00);
      do_write(7'h43, 2, 24'h123400);
      do_write(7'h42, 1, 24'h5E0000);
      do_read(7'h42, 2, 24'h960F00);

      // Repeated START after four bits of a data byte
      rx_got.delete();
      mstart();
      wbyte({MY_ADDR, 1'b0}, a);
      chk("rs_first_ack", 32'(a), 32'd1);
      for (int i = 7; i >= 4; i--) mbit(i[0], r);
      tx_data = 8'h6C;
      mstart();
      wbyte({MY_ADDR, 1'b1}, a);
      chk("rs_read_ack", 32'(a), 32'd1);
      chk("rs_rw", 32'(rw), 32'd1);
      chk("rs_no_rx", 32'(rx_got.size()), 32'd0);
      rbyte(1'b0, 8'h00, d);
      chk("rs_read_data", 32'(d), 32'h6C);
      mstop();

      // Reset while the slave is ACKing a received byte
      mstart();
      wbyte({MY_ADDR, 1'b0}, a);
      for (int i = 7; i >= 0; i--) begin
         d = 8'h11;
         mbit(d[i], r);
      end
      sda_m = 1'b1;
      tick(Q);
      chk("rr_acking", 32'(sda_oe), 32'd1);
      scl_m = 1'b1;
      tick(2);
      reset = 1'b1;
      #1;
      chk("rr_oe_now", 32'(sda_oe), 32'd0);
      chk("rr_rx_data", 32'(rx_data), 32'd0);
      chk("rr_busy", 32'(busy), 32'd0);
      chk("rr_rw", 32'(rw), 32'd0);
      tick(2);
      reset = 1'b0;
      tick(1);
      scl_m = 1'b0;
      tick(Q);
      rx_got.delete();
      oe_cnt = 0;
      wbyte({MY_ADDR, 1'b0}, a);
      wbyte(8'hC3, a);
      chk("rr_ignored_oe", 32'(oe_cnt), 32'd0);
      chk("rr_ignored_rx", 32'(rx_got.size()), 32'd0);
      chk("rr_ignored_busy", 32'(busy), 32'd0);
      do_write(7'h42, 1, 24'h7B0000);

      // STOP in the middle of a TX byte
      tx_data = 8'hF3;
      mstart();
      wbyte({MY_ADDR, 1'b1}, a);
      chk("st_ack", 32'(a), 32'd1);
      req0 = tx_req_cnt;
      for (int i = 0; i < 3; i++) begin
         mbit(1'b1, r);
         chk("st_bits", 32'(r), 32'd1);
      end
      mstop();
      chk("st_oe", 32'(sda_oe), 32'd0);
      chk("st_busy", 32'(busy), 32'd0);
      oe_cnt = 0;
      for (int i = 0; i < 9; i++) mbit(1'b1, r);
      chk("st_no_more_req", 32'(tx_req_cnt - req0), 32'd0);
      chk("st_no_drive", 32'(oe_cnt), 32'd0);
      mstop();

      for (int it = 0; it < 16; it++) begin
         logic [6:0] addr;
         int n;
         logic [23:0] dat;
         addr = ($urandom_range(0, 3) == 0) ? 7'($urandom) : MY_ADDR;
         n    = $urandom_range(1, 3);
         dat  = 24'($urandom);
         if ($urandom_range(0, 2) == 2) do_read(addr, n, dat);
         else do_write(addr, n, dat);
      end

      chk("no_rx_tx_overlap", 32'(overlap_cnt), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_slave_core.md
Name: i2c_slave_core

Overview:
- Byte-level I2C slave engine, downstream of the slave clock-conditioning stage; consumes the raw bus SCL/SDA, oversampled on system clock clk.
- Detects START/STOP and matches a 7-bit address.
- Receives write bytes, serves read bytes, and drives ACK.
- Presents a simple byte handshake to the register/application logic behind it.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit device address matched after START.
- SYNC_STAGES, 2, flip-flop stages on scl_i/sda_i before edge detection (min 2).

Ports:
- clk  input  1  system clock; must be at least 8x SCL frequency.
- reset  input  1  asynchronous, active-high.
- scl_i  input  1  bus SCL level (asynchronous).
- sda_i  input  1  bus SDA level (asynchronous).
- sda_oe  output  1  1 = pull SDA low (open-drain); pad drives 0 when set.
- rx_data  output  8  last received write byte.
- rx_valid  output  1  one-cycle pulse; rx_data valid.
- tx_req  output  1  one-cycle pulse; tx_data sampled this cycle.
- tx_data  input  8  byte to transmit on a read.
- rw  output  1  R/W bit of the current transaction (1 = read).
- busy  output  1  high from addressed ACK until STOP/NACK/mismatch.

Behaviour:
- Reset: sda_oe=0, rx_data=0, rx_valid=0, tx_req=0, rw=0, busy=0, state IDLE; synchronizers preset to 1 (idle bus).
- Sync and edge detect: scl_s/sda_s are the last sync stage; prev copies are registered one cycle.
  - scl_rise / scl_fall are single-cycle pulses.
  - Latency pin-to-pulse is SYNC_STAGES+1 cycles.
- START: sda_s falls while scl_s=1 and scl_s unchanged. STOP: sda_s rises while scl_s=1.
  - Both override every state, including mid-byte and mid-ACK.
  - START -> ADDR, bit counter=0, sda_oe=0.
  - STOP -> IDLE, sda_oe=0, busy=0.
- Data sampling and driving:
  - Data is sampled on scl_rise, MSB first.
  - sda_oe changes only on scl_fall, in the same cycle the fall is detected.
  - Exception: STOP/START/reset force sda_oe=0 immediately.
- States:
  - IDLE: ignore everything except START.
  - ADDR: shift 8 bits.
    - On the 8th scl_rise, compare bits[7:1] with SLAVE_ADDR and latch rw=bit0.
    - Match -> ACK_ADDR. Mismatch -> IDLE with no ACK; wait for the next START.
  - ACK_ADDR: sda_oe=1 from the next scl_fall; busy=1.
    - On the following scl_fall (end of the 9th clock): rw=0 -> sda_oe=0, go to RX.
    - rw=1 -> pulse tx_req, load shift reg from tx_data, drive MSB (sda_oe = ~bit7), go to TX.
  - RX: shift 8 bits.
    - On the 8th scl_rise: rx_data <= shift value, rx_valid pulse the same cycle, go to ACK_RX.
  - ACK_RX: sda_oe=1 on the next scl_fall; release on the following scl_fall; go to RX.
    - The slave always ACKs; no backpressure or clock stretching.
  - TX: on each scl_fall, drive the next bit (sda_oe = ~bit).
    - After the 8th bit's scl_fall, release (sda_oe=0) and go to WAIT_ACK.
  - WAIT_ACK: sample sda_s on scl_rise.
    - 0 (ACK) -> on the next scl_fall, tx_req pulse, load, drive MSB, go to TX.
    - 1 (NACK) -> sda_oe=0, busy=0, go to IDLE.
- Bit counter: 4-bit, cleared on START and on each state entry; 8 is terminal.
- Simultaneous events:
  - START/STOP detection wins over scl edges in the same cycle.
  - reset wins over all.
  - rx_valid and tx_req are never high in the same cycle.
- tx_data is sampled only in the tx_req cycle; the application holds it stable in that cycle (registered source).

Decomposition:
- Package i2c_pkg: state enum (IDLE, ADDR, ACK_ADDR, RX, ACK_RX, TX, WAIT_ACK) and the constant BYTE_BITS=8.
- One sub-module, i2c_bus_sync: SYNC_STAGES synchronizer for scl/sda plus rise/fall/START/STOP pulse generation.
- The core FSM and shift logic stay in i2c_slave_core.

Test Plan:
- Write to 0x42, bytes 0xA5, 0x3C, then STOP:
  - ACK on the address and on both bytes.
  - rx_valid pulses twice with rx_data 0xA5 then 0x3C.
  - busy falls on STOP.
- Address 0x43 write: no ACK (sda_oe stays 0 all 9 clocks), no rx_valid, busy stays 0, and the following START to 0x42 is accepted.
- Read from 0x42 with tx_data 0x96, master ACK, then tx_data 0x0F, master NACK:
  - Bus carries 0x96 then 0x0F.
  - tx_req pulses exactly twice.
  - sda_oe=0 and state IDLE after the NACK.
- Repeated START after the 4th bit of a write byte: no rx_valid; new address phase; a read to 0x42 is ACKed with rw=1.
- Assert reset while ACK_RX is driving sda_oe=1: sda_oe=0 within the same cycle, all outputs at reset values, and the core ignores SCL until the next START.
- STOP in the middle of a TX byte: sda_oe released immediately, busy=0, no further tx_req.
